// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : round-robin sequencer sharing one block-wide memory port
//               between icache refill and dcache refill/writeback.
// Revision    : 1.0
// ============================================================================
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int BLOCK_W = 256
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_req,
   input  logic [ADDR_W-1:0]  i_addr,
   output logic               i_ready,
   output logic [BLOCK_W-1:0] i_rdata,
   input  logic               d_req,
   input  logic               d_we,
   input  logic [ADDR_W-1:0]  d_addr,
   input  logic [BLOCK_W-1:0] d_wdata,
   output logic               d_ready,
   output logic [BLOCK_W-1:0] d_rdata,
   output logic               mem_req,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [BLOCK_W-1:0] mem_wdata,
   input  logic               mem_ready,
   input  logic [BLOCK_W-1:0] mem_rdata,
   output logic               owner,
   output logic               busy
);
   localparam int              OFFSET_W    = 5;
   localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((1 << OFFSET_W) - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_q;
   logic   last_q;   // 1 = dcache was served last
   logic   grant_d;  // owner of the next grant: 1 = dcache

   // dcache wins when it is the only requester, or on a tie after an icache turn
   assign grant_d = d_req & (~i_req | ~last_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         last_q    <= 1'b1;
         owner     <= 1'b0;
         busy      <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         i_ready   <= 1'b0;
         d_ready   <= 1'b0;
         i_rdata   <= '0;
         d_rdata   <= '0;
      end else begin
         i_ready <= 1'b0;
         d_ready <= 1'b0;
         case (state_q)
            IDLE: begin
               if (i_req | d_req) begin
                  owner     <= grant_d;
                  busy      <= 1'b1;
                  mem_req   <= 1'b1;
                  mem_we    <= grant_d & d_we;
                  mem_addr  <= (grant_d ? d_addr : i_addr) & ~OFFSET_MASK;
                  mem_wdata <= grant_d ? d_wdata : '0;
                  state_q   <= BUSY;
               end
            end
            BUSY: begin
               if (mem_ready) begin
                  mem_req <= 1'b0;
                  if (!mem_we) begin
                     if (owner) d_rdata <= mem_rdata;
                     else       i_rdata <= mem_rdata;
                  end
                  i_ready <= ~owner;
                  d_ready <= owner;
                  last_q  <= owner;
                  state_q <= DONE;
               end
            end
            DONE: begin
               busy    <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy    <= 1'b0;
               mem_req <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : directed scoreboard bench for mem_arbiter.
// Revision       : 1.0
// ============================================================================
module tb_mem_arbiter;
   logic         clk = 1'b0;
   logic         rst_n;
   logic         i_req, d_req, d_we, mem_ready;
   logic [31:0]  i_addr, d_addr;
   logic [255:0] d_wdata, mem_rdata;
   logic         i_ready, d_ready, mem_req, mem_we, owner, busy;
   logic [255:0] i_rdata, d_rdata, mem_wdata;
   logic [31:0]  mem_addr;

   typedef struct {
      logic         own;
      logic [255:0] data;
   } exp_t;

   exp_t         sb[$];
   logic [255:0] mdl_i, mdl_d;
   bit           auto_drop;
   int           checks = 0;
   int           errors = 0;

   mem_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ready(d_ready), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .owner(owner), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] req);
      checks++;
      assert (obs === req) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, req);
      end
   endtask

   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (i_ready || d_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL unexpected_ready: observed i_ready=%0b d_ready=%0b expected none", i_ready, d_ready);
         end else begin
            e = sb.pop_front();
            chk("ready_owner", {i_ready, d_ready}, e.own ? 2'b01 : 2'b10);
            chk("rdata", e.own ? d_rdata : i_rdata, e.data);
            chk("other_rdata", e.own ? i_rdata : d_rdata, e.own ? mdl_i : mdl_d);
         end
         if (auto_drop && i_ready) i_req = 1'b0;
         if (auto_drop && d_ready) d_req = 1'b0;
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_mem_req"}, mem_req, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_owner"}, owner, 0);
      chk({tag, "_readies"}, {i_ready, d_ready, mem_we}, 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_mem_wdata"}, mem_wdata, 0);
      chk({tag, "_i_rdata"}, i_rdata, 0);
      chk({tag, "_d_rdata"}, d_rdata, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      i_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
      i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
      sb.delete();
      mdl_i = '0;
      mdl_d = '0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Wait for a grant, check the latched request, answer after lat BUSY cycles.
   task automatic serve(input logic own, input logic [31:0] addr, input logic we,
                        input logic [255:0] wdata, input int lat, input logic [255:0] rdata);
      int   n = 0;
      exp_t e;
      while (!mem_req && n < 20) begin
         tick();
         n++;
      end
      if (!mem_req) begin
         checks++;
         errors++;
         $error("FAIL grant_timeout: observed mem_req=0 expected 1");
         return;
      end
      chk("mem_addr", mem_addr, addr);
      chk("mem_we", mem_we, we);
      chk("mem_wdata", mem_wdata, wdata);
      chk("owner", owner, own);
      chk("busy", busy, 1);
      for (int k = 1; k < lat; k++) begin
         tick();
         chk("hold_req", mem_req, 1);
         chk("hold_addr", mem_addr, addr);
      end
      e.own  = own;
      e.data = (own && we) ? mdl_d : rdata;
      if (own && !we) mdl_d = rdata;
      if (!own)       mdl_i = rdata;
      sb.push_back(e);
      mem_ready = 1'b1;
      mem_rdata = rdata;
      tick();
      mem_ready = 1'b0;
      for (int k = 0; k < 8; k++) mem_rdata[k*32 +: 32] = $urandom();
      chk("ready_pulse", own ? d_ready : i_ready, 1);
      chk("done_req_drop", mem_req, 0);
      chk("done_busy", busy, 1);
      chk("sb_drained", sb.size(), 0);
   endtask

   initial begin
      auto_drop = 1'b1;
      do_reset();
      chk_all_zero("reset");

      // single icache refill, 3-cycle memory latency
      i_req = 1; i_addr = 32'h0000_0047;
      serve(1'b0, 32'h0000_0040, 1'b0, '0, 3, {32{8'hA5}});
      tick();
      chk("i_rdata_hold", i_rdata, {32{8'hA5}});

      // dcache refill then writeback
      d_req = 1; d_we = 0; d_addr = 32'h0000_021F; d_wdata = {8{32'hDEAD_BEEF}};
      serve(1'b1, 32'h0000_0200, 1'b0, {8{32'hDEAD_BEEF}}, 2, {32{8'h5A}});
      tick();
      d_req = 1; d_we = 1; d_addr = 32'h0000_0100; d_wdata = {8{32'h1234_5678}};
      serve(1'b1, 32'h0000_0100, 1'b1, {8{32'h1234_5678}}, 2, {256{1'b1}});
      tick();
      chk("d_rdata_after_write", d_rdata, {32{8'h5A}});

      // simultaneous requests alternate I, D, I, D
      do_reset();
      auto_drop = 1'b0;
      i_req = 1; i_addr = 32'h0000_0500;
      d_req = 1; d_we = 0; d_addr = 32'h0000_0600;
      serve(1'b0, 32'h0000_0500, 1'b0, '0, 1, {8{32'h1111_0001}});
      tick();
      chk("bubble_busy", busy, 0);
      serve(1'b1, 32'h0000_0600, 1'b0, '0, 2, {8{32'h2222_0002}});
      serve(1'b0, 32'h0000_0500, 1'b0, '0, 1, {8{32'h3333_0003}});
      serve(1'b1, 32'h0000_0600, 1'b0, '0, 3, {8{32'h4444_0004}});
      i_req = 0;
      d_req = 0;
      auto_drop = 1'b1;
      tick();

      // spurious mem_ready in IDLE, then address change mid-BUSY
      mem_ready = 1;
      tick();
      mem_ready = 0;
      chk("spurious_busy", busy, 0);
      chk("spurious_req", mem_req, 0);
      tick();
      chk("spurious_busy2", busy, 0);
      i_req = 1; i_addr = 32'h1000_0013;
      tick();
      i_addr = 32'hFFFF_FFE0;
      serve(1'b0, 32'h1000_0000, 1'b0, '0, 3, {8{32'hCAFE_F00D}});
      tick();

      // async reset during BUSY, then tie after release goes to icache
      d_req = 1; d_we = 0; d_addr = 32'h0000_0300;
      tick();
      chk("pre_reset_req", mem_req, 1);
      chk("pre_reset_owner", owner, 1);
      i_req = 1; i_addr = 32'h0000_0440;
      #2 rst_n = 0;
      #1 chk_all_zero("async_reset");
      sb.delete();
      mdl_i = '0;
      mdl_d = '0;
      tick();
      rst_n = 1;
      serve(1'b0, 32'h0000_0440, 1'b0, '0, 2, {8{32'h0BAD_CAFE}});
      serve(1'b1, 32'h0000_0300, 1'b0, '0, 1, {8{32'h7777_8888}});
      tick();

      // minimum latency: req cycle 0, mem_req cycle 1, ready cycle 2
      i_req = 1; i_addr = 32'h0000_07FF;
      tick();
      chk("lat_mem_req", mem_req, 1);
      serve(1'b0, 32'h0000_07E0, 1'b0, '0, 1, {8{32'h9999_AAAA}});
      tick();
      chk("post_done_busy", busy, 0);
      chk("post_done_ready", i_ready, 0);
      chk("post_done_req", mem_req, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
